// File: rtl/gcapply_if.sv
// Bin-stream and gain-RAM signal bundle for the gcapply spectral gain stage.
// Valid-only stream, no ready: a beat transfers on every rising clk edge with xk_dv/yk_dv high.
interface gcapply_if #(
   parameter int LOGFFTSIZE = 10,
   parameter int AUDIOWIDTH = 16,
   parameter int GCRVEWIDTH = 8
);
   logic                         enable;
   logic                         xk_dv;
   logic [LOGFFTSIZE-1:0]        xk_index;
   logic signed [AUDIOWIDTH-1:0] xk_re;
   logic signed [AUDIOWIDTH-1:0] xk_im;

   logic [LOGFFTSIZE-1:0]        gcurve_addr;
   logic [GCRVEWIDTH-1:0]        gcurve_dout;

   logic                         yk_dv;
   logic [LOGFFTSIZE-1:0]        yk_index;
   logic signed [AUDIOWIDTH-1:0] yk_re;
   logic signed [AUDIOWIDTH-1:0] yk_im;
   logic                         frame_done;
   logic                         sat;
   logic                         sat_sticky;

   modport master (
      output enable, xk_dv, xk_index, xk_re, xk_im, gcurve_dout,
      input  gcurve_addr, yk_dv, yk_index, yk_re, yk_im, frame_done, sat, sat_sticky
   );

   modport slave (
      input  enable, xk_dv, xk_index, xk_re, xk_im, gcurve_dout,
      output gcurve_addr, yk_dv, yk_index, yk_re, yk_im, frame_done, sat, sat_sticky
   );
endinterface

// File: rtl/gcapply.sv
// Spectral gain stage between FFT and IFFT: per-bin gain from the curve RAM,
// round-half-up and saturate, three register stages, one bin per clock.
module gcapply #(
   parameter int LOGFFTSIZE = 10,
   parameter int AUDIOWIDTH = 16,
   parameter int GCRVEWIDTH = 8,
   parameter int MIRROR     = 0
) (
   input logic      clk,
   input logic      rst,
   gcapply_if.slave bus
);
   localparam int L  = LOGFFTSIZE;
   localparam int A  = AUDIOWIDTH;
   localparam int G  = GCRVEWIDTH;
   localparam int PW = A + G + 1;

   localparam logic [L-1:0]        HALF  = {1'b1, {(L-1){1'b0}}};
   localparam logic [L-1:0]        LAST  = {L{1'b1}};
   localparam logic [L-1:0]        ONE   = {{(L-1){1'b0}}, 1'b1};
   localparam logic [G-1:0]        UNITY = {1'b1, {(G-1){1'b0}}};
   localparam logic signed [PW-1:0] RND  = {{(PW-G+1){1'b0}}, 1'b1, {(G-2){1'b0}}};
   localparam logic signed [PW-1:0] MAXV = {{(PW-A+1){1'b0}}, {(A-1){1'b1}}};
   localparam logic signed [PW-1:0] MINV = {{(PW-A+1){1'b1}}, {(A-1){1'b0}}};
   localparam logic [A-1:0]        MAXO  = {1'b0, {(A-1){1'b1}}};
   localparam logic [A-1:0]        MINO  = {1'b1, {(A-1){1'b0}}};

   // Address: mirrored bins fold onto N-k, which is two's complement in L bits.
   logic [L-1:0] addr_d;

   always_comb begin
      addr_d = bus.xk_index;
      if (MIRROR != 0 && bus.xk_index > HALF) addr_d = ~bus.xk_index + ONE;
   end

   assign bus.gcurve_addr = addr_d;

   // P1: sample waits here while the RAM returns its gain word.
   logic                p1_dv_q;
   logic                p1_en_q;
   logic [L-1:0]        p1_idx_q;
   logic signed [A-1:0] p1_re_q;
   logic signed [A-1:0] p1_im_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_dv_q  <= 1'b0;
         p1_en_q  <= 1'b0;
         p1_idx_q <= '0;
         p1_re_q  <= '0;
         p1_im_q  <= '0;
      end else begin
         p1_dv_q <= bus.xk_dv;
         if (bus.xk_dv) begin
            p1_en_q  <= bus.enable;
            p1_idx_q <= bus.xk_index;
            p1_re_q  <= bus.xk_re;
            p1_im_q  <= bus.xk_im;
         end
      end
   end

   logic [G-1:0]         gain_d;
   logic signed [G:0]    gain_s;
   logic signed [PW-1:0] prod_re_d;
   logic signed [PW-1:0] prod_im_d;

   always_comb begin
      gain_d    = p1_en_q ? bus.gcurve_dout : UNITY;
      gain_s    = $signed({1'b0, gain_d});
      prod_re_d = PW'(p1_re_q) * PW'(gain_s);
      prod_im_d = PW'(p1_im_q) * PW'(gain_s);
   end

   // P2: full-precision products.
   logic                 p2_dv_q;
   logic [L-1:0]         p2_idx_q;
   logic signed [PW-1:0] p2_re_q;
   logic signed [PW-1:0] p2_im_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p2_dv_q  <= 1'b0;
         p2_idx_q <= '0;
         p2_re_q  <= '0;
         p2_im_q  <= '0;
      end else begin
         p2_dv_q <= p1_dv_q;
         if (p1_dv_q) begin
            p2_idx_q <= p1_idx_q;
            p2_re_q  <= prod_re_d;
            p2_im_q  <= prod_im_d;
         end
      end
   end

   // Returns {clamped, value}; the shift is arithmetic so negatives round toward +inf at .5.
   function automatic logic [A:0] round_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] s;
      s = (p + RND) >>> (G - 1);
      if (s > MAXV)      return {1'b1, MAXO};
      else if (s < MINV) return {1'b1, MINO};
      else               return {1'b0, s[A-1:0]};
   endfunction

   logic [A-1:0] re_d;
   logic [A-1:0] im_d;
   logic         sat_re_d;
   logic         sat_im_d;
   logic         sat_d;
   logic         fd_d;

   always_comb begin
      {sat_re_d, re_d} = round_sat(p2_re_q);
      {sat_im_d, im_d} = round_sat(p2_im_q);
      sat_d = p2_dv_q & (sat_re_d | sat_im_d);
      fd_d  = p2_dv_q & (p2_idx_q == LAST);
   end

   // P3: output register.
   logic                yk_dv_q;
   logic [L-1:0]        yk_idx_q;
   logic signed [A-1:0] yk_re_q;
   logic signed [A-1:0] yk_im_q;
   logic                fd_q;
   logic                sat_q;
   logic                sticky_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         yk_dv_q  <= 1'b0;
         yk_idx_q <= '0;
         yk_re_q  <= '0;
         yk_im_q  <= '0;
         fd_q     <= 1'b0;
         sat_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         yk_dv_q  <= p2_dv_q;
         fd_q     <= fd_d;
         sat_q    <= sat_d;
         sticky_q <= sticky_q | sat_d;
         if (p2_dv_q) begin
            yk_idx_q <= p2_idx_q;
            yk_re_q  <= re_d;
            yk_im_q  <= im_d;
         end
      end
   end

   assign bus.yk_dv      = yk_dv_q;
   assign bus.yk_index   = yk_idx_q;
   assign bus.yk_re      = yk_re_q;
   assign bus.yk_im      = yk_im_q;
   assign bus.frame_done = fd_q;
   assign bus.sat        = sat_q;
   assign bus.sat_sticky = sticky_q;
endmodule

// File: doc/gcapply.md
# gcapply

Spectral gain stage sitting between the forward FFT and the inverse FFT. For every FFT output bin it reads the matching entry of the gain-curve RAM (the RAM filled by the serial gain-curve loader), multiplies the bin's real and imaginary parts by that gain, and rounds and saturates the result. It then streams the result to the IFFT with the bin index and a valid strobe. The stage is fully pipelined with no backpressure, and accepts one bin per clock.

## Interface
Parameters:
- LOGFFTSIZE, 10, log2 of FFT length N; bin index width
- AUDIOWIDTH, 16, signed width of bin real/imag parts, in and out
- GCRVEWIDTH, 8, unsigned gain word width; format Q1.(GCRVEWIDTH-1), unity = 2^(GCRVEWIDTH-1)
- MIRROR, 0, 1 = bins k > N/2 use gain entry N-k (conjugate symmetry); 0 = entry k

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = apply curve; 0 = bypass (gain forced to unity); sampled with xk_dv
- xk_dv  in  1  input bin valid
- xk_index  in  LOGFFTSIZE  input bin number
- xk_re, xk_im  in  AUDIOWIDTH  signed input bin
- gcurve_addr  out  LOGFFTSIZE  gain RAM read address; combinational from xk_index
- gcurve_dout  in  GCRVEWIDTH  gain RAM read data; valid exactly 1 cycle after address
- yk_dv  out  1  output bin valid
- yk_index  out  LOGFFTSIZE  output bin number
- yk_re, yk_im  out  AUDIOWIDTH  signed scaled bin
- frame_done  out  1  one-cycle pulse with the output beat whose yk_index = N-1
- sat  out  1  one-cycle pulse on any output beat where re or im saturated
- sat_sticky  out  1  set by sat; cleared only by rst

## Operation
- Address: MIRROR=0 -> gcurve_addr = xk_index. MIRROR=1 -> xk_index if xk_index <= N/2, else N - xk_index (LOGFFTSIZE-bit arithmetic; index 0 maps to 0).
- Gain g: gcurve_dout when enable is high at the sample's input cycle; otherwise 2^(GCRVEWIDTH-1). The enable bit is pipelined alongside the data, so a mid-frame toggle affects only later bins.
- Multiply: the signed x (AUDIOWIDTH) is multiplied by g zero-extended to GCRVEWIDTH+1 signed bits. The full-precision product is AUDIOWIDTH+GCRVEWIDTH+1 bits.
- Round: add 2^(GCRVEWIDTH-2), then arithmetic shift right by GCRVEWIDTH-1 (round half up).
- Saturate: clamp to [-2^(AUDIOWIDTH-1), 2^(AUDIOWIDTH-1)-1]. Assert sat if either component clamped.
- Pipeline registers: P1 holds x, index, enable and dv while the RAM returns g. P2 holds products, index and dv. P3 drives the outputs.
- Bins are not reordered. Every index is passed through unchanged, and the block never checks index ordering.
- Gaps in xk_dv propagate as gaps in yk_dv. Back-to-back frames need no idle cycle.
- The block does not arbitrate the gain RAM write port. A curve rewrite during streaming yields a mix of old and new gains, which is acceptable.

## Timing
- Latency: a bin presented at cycle t with xk_dv=1 appears at cycle t+3 with yk_dv=1.
- Throughput: 1 bin/clock sustained, indefinitely.
- gcurve_addr changes in the same cycle as xk_index. The block captures gcurve_dout at t+1.
- frame_done and sat are coincident with the yk_dv beat they describe. Both are never high when yk_dv=0.
- Reset values: yk_dv=0, yk_index=0, yk_re=0, yk_im=0, frame_done=0, sat=0, sat_sticky=0, all pipeline valids 0.
- Reset mid-stream: in-flight samples are discarded. No yk_dv occurs for cycles t+1..t+3 after the rst cycle unless a new xk_dv arrives after rst deasserts.
- Input with xk_dv=0 never produces yk_dv, frame_done or sat, whatever the data values are.

## Test plan
- Unity: GCRVEWIDTH=8, all gains 128, random bins, N=1024 -> yk equals xk exactly, latency 3, frame_done once, at index 1023.
- Zero and half gain: gain[5]=0, gain[6]=64, x=(1001,-1001) -> bin 5 gives (0,0). Bin 6 gives (501,-500), exercising round half up.
- Saturation: gain=255, x=(32767,-32768) -> outputs (32767,-32768), sat pulse, sat_sticky stays 1 until rst.
- Mirror: MIRROR=1, gain[k]=k, feed index 1000 -> gcurve_addr=24. Index 512 -> 512. Index 0 -> 0.
- Bypass toggle: curve all 0, enable low for bins 0..99 then high -> bins 0..99 pass unchanged, bins 100+ zero, with no glitch at the boundary.
- Stream control: inject 2-cycle xk_dv gaps, then assert rst one cycle after a valid beat -> gaps preserved in yk_dv; after reset no stale yk_dv; restart yields a correct frame.
